// File: rtl/vga_sync_detect_pkg.sv
// Shared 800x600@72 timing constants, counter widths, detector state encoding and
// saturating-counter helpers for the VGA sync detector.
package vga_sync_detect_pkg;

    // 800x600@72: 50 MHz pixel clock, 1040 x 666 total.
    localparam int VGA_H_VISIBLE     = 800;
    localparam int VGA_H_FRONT_PORCH = 56;
    localparam int VGA_H_SYNC        = 120;
    localparam int VGA_H_BACK_PORCH  = 64;
    localparam int VGA_H_PIXELS      = VGA_H_VISIBLE + VGA_H_FRONT_PORCH + VGA_H_SYNC + VGA_H_BACK_PORCH;
    localparam int VGA_V_VISIBLE     = 600;
    localparam int VGA_V_FRONT_PORCH = 37;
    localparam int VGA_V_SYNC        = 6;
    localparam int VGA_V_BACK_PORCH  = 23;
    localparam int VGA_V_PIXELS      = VGA_V_VISIBLE + VGA_V_FRONT_PORCH + VGA_V_SYNC + VGA_V_BACK_PORCH;

    localparam int DEF_LOCK_LINES = 4;
    localparam int DEF_H_TOL      = 0;

    // Published measurements are 11 bits; the line counter carries one extra bit so
    // the missing-sync watchdog at 2*H_PIXELS (2080) is reachable.
    localparam int CNT_W  = 11;
    localparam int LINE_W = CNT_W + 1;
    localparam int GOOD_W = 8;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [LINE_W-1:0] LINE_MAX = '1;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } det_state_e;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [LINE_W-1:0] line_inc(input logic [LINE_W-1:0] v);
        return (v == LINE_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] clamp_meas(input logic [LINE_W-1:0] v);
        return (v > {1'b0, CNT_MAX}) ? CNT_MAX : v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/vga_sync_detect_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous sync input followed by a registered
// rising-edge pulse; the pulse appears three clocks after the input rises.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic edge_o
);

    logic [2:0] sync_q;
    logic       edge_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
            edge_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/vga_sync_detect.sv
// VGA timing receiver: measures line/frame periods from h/v sync, locks onto nominal
// timing and regenerates x/y/display_en. Define VGA_SYNC_DETECT_STATS_EN for lock_loss_cnt.
module vga_sync_detect
    import vga_sync_detect_pkg::*;
#(
    parameter int H_VISIBLE     = VGA_H_VISIBLE,
    parameter int H_PIXELS      = VGA_H_PIXELS,
    parameter int H_FRONT_PORCH = VGA_H_FRONT_PORCH,
    parameter int V_VISIBLE     = VGA_V_VISIBLE,
    parameter int V_PIXELS      = VGA_V_PIXELS,
    parameter int V_FRONT_PORCH = VGA_V_FRONT_PORCH,
    parameter int LOCK_LINES    = DEF_LOCK_LINES,
    parameter int H_TOL         = DEF_H_TOL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             h_sync_in,
    input  logic             v_sync_in,
    output logic             locked,
    output logic             display_en,
    output logic [CNT_W-1:0] x_pos,
    output logic [CNT_W-1:0] y_pos,
    output logic             frame_start,
    output logic [CNT_W-1:0] h_meas,
    output logic [CNT_W-1:0] v_meas
`ifdef VGA_SYNC_DETECT_STATS_EN
    ,
    output logic [15:0]      lock_loss_cnt
`endif
);

    localparam int H_LEAD = H_PIXELS - H_VISIBLE - H_FRONT_PORCH;
    localparam int V_LEAD = V_PIXELS - V_VISIBLE - V_FRONT_PORCH;

    localparam logic [LINE_W-1:0] H_LEAD_L    = LINE_W'(H_LEAD);
    localparam logic [LINE_W-1:0] H_END_L     = LINE_W'(H_LEAD + H_VISIBLE);
    localparam logic [LINE_W-1:0] H_MIN_L     = LINE_W'(H_PIXELS - H_TOL);
    localparam logic [LINE_W-1:0] H_MAX_L     = LINE_W'(H_PIXELS + H_TOL);
    localparam logic [LINE_W-1:0] H_TIMEOUT_L = LINE_W'(2 * H_PIXELS);
    localparam logic [CNT_W-1:0]  H_LEAD_C    = CNT_W'(H_LEAD);
    localparam logic [CNT_W-1:0]  V_LEAD_C    = CNT_W'(V_LEAD);
    localparam logic [CNT_W-1:0]  V_END_C     = CNT_W'(V_LEAD + V_VISIBLE);
    localparam logic [CNT_W-1:0]  V_PIX_C     = CNT_W'(V_PIXELS);
    localparam logic [GOOD_W-1:0] LOCK_C      = GOOD_W'(LOCK_LINES);

    logic h_edge, v_edge;

    sync_edge_det u_h_edge (.clk(clk), .rst(rst), .async_i(h_sync_in), .edge_o(h_edge));
    sync_edge_det u_v_edge (.clk(clk), .rst(rst), .async_i(v_sync_in), .edge_o(v_edge));

    logic [LINE_W-1:0] h_cnt_q, h_cnt_d, h_len;
    logic [CNT_W-1:0]  v_cnt_q, v_cnt_d, f_len;
    logic [CNT_W-1:0]  h_meas_q, h_meas_d, v_meas_q, v_meas_d;
    logic              v_arm_q, v_arm_d;
    logic              frame_end, line_good, frame_good, timeout;

    // A v-edge only arms the line reset; the h-edge that follows closes the frame,
    // so an h-edge in the same cycle still counts as the old frame's last line.
    always_comb begin
        h_len      = line_inc(h_cnt_q);
        f_len      = cnt_inc(v_cnt_q);
        frame_end  = h_edge & v_arm_q;
        line_good  = (h_len >= H_MIN_L) && (h_len <= H_MAX_L);
        frame_good = (f_len == V_PIX_C);
        timeout    = !h_edge && (h_len == H_TIMEOUT_L);
        h_cnt_d    = h_edge ? '0 : h_len;
        h_meas_d   = h_edge ? clamp_meas(h_len) : h_meas_q;
        v_cnt_d    = v_cnt_q;
        v_meas_d   = v_meas_q;
        if (h_edge) begin
            if (v_arm_q) begin
                v_cnt_d  = '0;
                v_meas_d = f_len;
            end else begin
                v_cnt_d  = f_len;
            end
        end
        v_arm_d = v_edge | (v_arm_q & ~h_edge);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            h_meas_q <= '0;
            v_meas_q <= '0;
            v_arm_q  <= 1'b0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            h_meas_q <= h_meas_d;
            v_meas_q <= v_meas_d;
            v_arm_q  <= v_arm_d;
        end
    end

    det_state_e        state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d, good_inc;
    logic              armed_q, armed_d;

    // CHECK: after LOCK_LINES good lines the next frame boundary arms the frame check,
    // so the frame that decides lock is observed from its first line.
    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        armed_d  = armed_q;
        good_inc = (good_q >= LOCK_C) ? good_q : good_q + 1'b1;
        unique case (state_q)
            ST_SEARCH: begin
                if (h_edge && line_good) begin
                    state_d = ST_CHECK;
                    good_d  = 8'd1;
                    armed_d = 1'b0;
                end
            end
            ST_CHECK: begin
                if (h_edge) begin
                    if (!line_good) begin
                        state_d = ST_SEARCH;
                        good_d  = '0;
                        armed_d = 1'b0;
                    end else begin
                        good_d = good_inc;
                        if (frame_end && (good_inc >= LOCK_C)) begin
                            if (armed_q && frame_good) state_d = ST_LOCKED;
                            else                       armed_d = 1'b1;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if ((h_edge && (!line_good || (frame_end && !frame_good))) || timeout) begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                    armed_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = '0;
                armed_d = 1'b0;
            end
        endcase
    end

    logic             locked_q, display_en_q, frame_start_q;
    logic [CNT_W-1:0] x_pos_q, y_pos_q;
    logic             lock_d, in_window;

    assign lock_d    = (state_d == ST_LOCKED);
    assign in_window = (h_cnt_q >= H_LEAD_L) && (h_cnt_q < H_END_L) &&
                       (v_cnt_q >= V_LEAD_C) && (v_cnt_q < V_END_C);

`ifdef VGA_SYNC_DETECT_STATS_EN
    logic [15:0] lock_loss_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SEARCH;
            good_q        <= '0;
            armed_q       <= 1'b0;
            locked_q      <= 1'b0;
            display_en_q  <= 1'b0;
            frame_start_q <= 1'b0;
            x_pos_q       <= '0;
            y_pos_q       <= '0;
`ifdef VGA_SYNC_DETECT_STATS_EN
            lock_loss_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            armed_q  <= armed_d;
            locked_q <= lock_d;
            if (lock_d && in_window) begin
                display_en_q  <= 1'b1;
                frame_start_q <= (h_cnt_q == H_LEAD_L) && (v_cnt_q == V_LEAD_C);
                x_pos_q       <= h_cnt_q[CNT_W-1:0] - H_LEAD_C;
                y_pos_q       <= v_cnt_q - V_LEAD_C;
            end else begin
                display_en_q  <= 1'b0;
                frame_start_q <= 1'b0;
                x_pos_q       <= '0;
                y_pos_q       <= '0;
            end
`ifdef VGA_SYNC_DETECT_STATS_EN
            if (state_q == ST_LOCKED && state_d == ST_SEARCH && lock_loss_q != 16'hFFFF)
                lock_loss_q <= lock_loss_q + 16'd1;
`endif
        end
    end

    assign locked      = locked_q;
    assign display_en  = display_en_q;
    assign frame_start = frame_start_q;
    assign x_pos       = x_pos_q;
    assign y_pos       = y_pos_q;
    assign h_meas      = h_meas_q;
    assign v_meas      = v_meas_q;
`ifdef VGA_SYNC_DETECT_STATS_EN
    assign lock_loss_cnt = lock_loss_q;
`endif

endmodule
